planificador_croma: RTL
=======================

# planificador_croma

Frame-synchronous command scheduler for the VGA colour path. It takes the four debounced button levels (TC, Up, Down, Lp) and turns each rising edge into a command. Commands are queued in a small FIFO and applied to the colour registers (ColorL, ColorP, ton) only during vertical blanking, so a colour or tone change never lands mid-frame. It sits between the debouncers and controldesalida and is driven by the vertical counter.

## Interface
Parameters:
- VIS_LINES, 480, first blanking line; visible lines are 0..VIS_LINES-1
- TOTAL_LINES, 525, vertical period; cntVertical runs 0..TOTAL_LINES-1
- FIFO_DEPTH, 4, command queue depth (power of 2)
- TON_STEP, 16, ton increment/decrement per Up/Down
- COLORL_RST, 3'b111, ColorL reset value
- COLORP_RST, 3'b000, ColorP reset value
- TON_RST, 8'h80, ton reset value

Ports:
- Clk  in  1  pixel clock; all state is on its rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- cntVertical  in  10  current line from contadorvertical
- TC  in  1  debounced level; toggles the edit target
- Up  in  1  debounced level; increases ton
- Down  in  1  debounced level; decreases ton
- Lp  in  1  debounced level; advances the selected colour
- ColorL  out  3  letter colour
- ColorP  out  3  background colour
- ton  out  8  tone value
- sel  out  1  edit target (0 = ColorL, 1 = ColorP)
- pending  out  log2(FIFO_DEPTH)+1  FIFO occupancy
- ovf  out  1  sticky: a command was dropped

## Operation
- Edge detect: one register per input. A command is issued on each 0->1 transition. Holding a level issues no further commands.
- Same-cycle edges: only one command is enqueued, chosen by priority TC > Lp > Up > Down. The lower-priority edges are discarded and set ovf.
- FIFO: 2-bit command code (TC=0, Lp=1, Up=2, Down=3), FIFO_DEPTH entries.
  - Push to a full FIFO: the command is dropped and ovf is set.
  - Push and pop in the same cycle are both allowed; occupancy is unchanged.
- FSM states:
  - VISIBLE: while cntVertical < VIS_LINES. No pops. Go to DRAIN when cntVertical >= VIS_LINES.
  - DRAIN: pop one command per clock while the FIFO is non-empty and cntVertical >= VIS_LINES. Go to HOLD when the FIFO is empty. Go to VISIBLE when cntVertical < VIS_LINES, i.e. after it wraps to 0; any remaining entries wait for the next blank.
  - HOLD: blanking with an empty FIFO. Commands pushed during HOLD return the FSM to DRAIN and are applied in the same blank. Go to VISIBLE when cntVertical < VIS_LINES.
- Command effects, applied on pop:
  - TC: sel <= ~sel.
  - Lp: if sel=0, ColorL <= ColorL+1; if sel=1, ColorP <= ColorP+1. Both are 3-bit and wrap 7->0.
  - Up: ton <= min(ton+TON_STEP, 255), computed in 9 bits and saturated.
  - Down: ton <= max(ton-TON_STEP, 0), saturated, never wraps.
- ovf clears only on Reset.

## Timing
- Reset values: ColorL=COLORL_RST, ColorP=COLORP_RST, ton=TON_RST, sel=0, pending=0, ovf=0. FSM=VISIBLE, FIFO empty, edge registers=0.
  - A level already high when Reset releases is treated as already seen and issues no command.
- Latency, edge to queue: an input rising at edge n gives pending+1 after edge n+1.
- Latency, pop to output: a command popped at edge m is visible on the outputs after edge m; all outputs are registered.
- Visible region: no output changes while cntVertical < VIS_LINES.
- Throughput: at most one command is applied per clock, and a full FIFO drains in FIFO_DEPTH cycles of blank.
- Reset mid-DRAIN: the FIFO is flushed, popped effects revert to their reset values, and unapplied commands are lost.

## Test plan
- Reset release at line 100, pulse Up once, run to line 480 -> ton stays 8'h80 through line 479; ton=8'h90 one cycle after the pop at line 480; pending returns to 0.
- Five Up pulses at line 10 -> pending saturates at 4 and ovf=1. At blank, ton steps 0x90, 0xA0, 0xB0, 0xC0 on four consecutive clocks.
- ton=8'hF8, Up applied -> ton=8'hFF. Then ton=8'h08, Down applied -> ton=8'h00 with no wrap.
- TC then Lp queued in visible region -> at blank, sel=1, then ColorP=3'b001 on the next clock, ColorL unchanged. With ColorP=7, Lp gives ColorP=0.
- TC and Down rising in the same cycle -> only TC is enqueued (pending=1) and ovf=1.
- Four commands queued, Reset asserted on the second DRAIN cycle -> all outputs return to reset values immediately and pending=0. After release, no change occurs at the next blank.

Source files
------------

// File: rtl/planificador_croma.sv
// Frame-synchronous colour/tone command scheduler: button edges are queued and
// applied to ColorL/ColorP/ton only while cntVertical is in vertical blanking.
module planificador_croma #(
  parameter int unsigned VIS_LINES   = 480,
  parameter int unsigned TOTAL_LINES = 525,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TON_STEP    = 16,
  parameter logic [2:0]  COLORL_RST  = 3'b111,
  parameter logic [2:0]  COLORP_RST  = 3'b000,
  parameter logic [7:0]  TON_RST     = 8'h80
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [9:0]                    cntVertical,
  input  logic                          TC,
  input  logic                          Up,
  input  logic                          Down,
  input  logic                          Lp,
  output logic [2:0]                    ColorL,
  output logic [2:0]                    ColorP,
  output logic [7:0]                    ton,
  output logic                          sel,
  output logic [$clog2(FIFO_DEPTH):0]   pending,
  output logic                          ovf
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [8:0] Step9 = 9'(TON_STEP);
  localparam logic [7:0] Step8 = 8'(TON_STEP);

  localparam logic [1:0] CmdTc   = 2'd0;
  localparam logic [1:0] CmdLp   = 2'd1;
  localparam logic [1:0] CmdUp   = 2'd2;
  localparam logic [1:0] CmdDown = 2'd3;

  typedef enum logic [1:0] {StVisible, StDrain, StHold} state_e;

  state_e          state_q, state_d;
  logic            armed_q;
  logic [3:0]      lvl_q;
  logic [3:0]      lvl, rise;
  logic            push, multi, accept, drop, pop, full, empty, in_blank;
  logic [1:0]      push_cmd, head;
  logic [1:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_q, rd_q;
  logic [PtrW:0]   count_q, count_d;
  logic [2:0]      colorl_q, colorl_d, colorp_q, colorp_d;
  logic [7:0]      ton_q, ton_d, ton_up, ton_dn;
  logic [8:0]      ton_sum;
  logic            sel_q, sel_d, ovf_q, ovf_d;

  // Bit order follows command priority: TC > Lp > Up > Down.
  assign lvl   = {TC, Lp, Up, Down};
  // armed_q masks the first clock after reset so levels already high are not edges.
  assign rise  = lvl & ~lvl_q & {4{armed_q}};
  assign push  = |rise;
  assign multi = |(rise & (rise - 4'd1));

  always_comb begin
    push_cmd = CmdDown;
    if (rise[3])      push_cmd = CmdTc;
    else if (rise[2]) push_cmd = CmdLp;
    else if (rise[1]) push_cmd = CmdUp;
  end

  assign in_blank = (cntVertical >= 10'(VIS_LINES)) && (cntVertical < 10'(TOTAL_LINES));
  assign full     = (count_q == FullCount);
  assign empty    = (count_q == '0);
  assign pop      = (state_q == StDrain) && in_blank && !empty;
  assign accept   = push && (!full || pop);
  assign drop     = push && !accept;
  assign head     = mem_q[rd_q];

  always_comb begin
    count_d = count_q;
    unique case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StVisible: if (in_blank) state_d = StDrain;
      StDrain: begin
        if (!in_blank)   state_d = StVisible;
        else if (empty)  state_d = StHold;
      end
      StHold: begin
        if (!in_blank)   state_d = StVisible;
        else if (!empty) state_d = StDrain;
      end
      default: state_d = StVisible;
    endcase
  end

  assign ton_sum = {1'b0, ton_q} + Step9;
  assign ton_up  = ton_sum[8] ? 8'hFF : ton_sum[7:0];
  assign ton_dn  = (ton_q < Step8) ? 8'h00 : ton_q - Step8;

  always_comb begin
    colorl_d = colorl_q;
    colorp_d = colorp_q;
    ton_d    = ton_q;
    sel_d    = sel_q;
    ovf_d    = ovf_q | drop | multi;
    if (pop) begin
      unique case (head)
        CmdTc:   sel_d = ~sel_q;
        CmdLp: begin
          if (sel_q) colorp_d = colorp_q + 3'd1;
          else       colorl_d = colorl_q + 3'd1;
        end
        CmdUp:   ton_d = ton_up;
        CmdDown: ton_d = ton_dn;
        default: ton_d = ton_q;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= StVisible;
      armed_q  <= 1'b0;
      lvl_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      colorl_q <= COLORL_RST;
      colorp_q <= COLORP_RST;
      ton_q    <= TON_RST;
      sel_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      armed_q  <= 1'b1;
      lvl_q    <= lvl;
      if (accept) wr_q <= wr_q + 1'b1;
      if (pop)    rd_q <= rd_q + 1'b1;
      count_q  <= count_d;
      colorl_q <= colorl_d;
      colorp_q <= colorp_d;
      ton_q    <= ton_d;
      sel_q    <= sel_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (accept) mem_q[wr_q] <= push_cmd;
  end

  assign ColorL  = colorl_q;
  assign ColorP  = colorp_q;
  assign ton     = ton_q;
  assign sel     = sel_q;
  assign pending = count_q;
  assign ovf     = ovf_q;

endmodule
